// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> little-endian words -> instruction memory, holds core in reset until loaded.
// Optional checksum byte and check enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  core_rst_o,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0]  MAGIC     = 8'hA5;
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_t      state, state_next;
  logic [7:0]  len_lo;
  logic [15:0] n_words;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_word;
  logic        accept;
  logic [15:0] rx_count;
  logic        last_byte;
  logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign accept    = rx_valid & rx_ready;
  assign rx_count  = {rx_data, len_lo};
  assign last_byte = (byte_cnt == 2'd3);
  assign last_word = (word_cnt == (n_words - 16'd1));

  always_ff @(posedge clk) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept && rx_data == MAGIC) state_next = S_LEN_LO;
      S_LEN_LO: if (accept) state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (rx_count == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_next = S_CSUM;
`else
            state_next = S_DONE;
`endif
          end else if ({1'b0, rx_count} > MAX_WORDS) begin
            state_next = S_ERR;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept && last_byte && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = S_CSUM;
`else
          state_next = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) state_next = (rx_data == csum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE:   state_next = S_DONE;
      S_ERR:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready   = (state != S_DONE) && (state != S_ERR);
    core_rst_o = (state != S_DONE);
    done       = (state == S_DONE);
  end

  // Word assembly and the registered write port; the write of the final word
  // issues on the same edge that leaves DATA.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      error    <= 1'b0;
      len_lo   <= '0;
      n_words  <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      asm_word <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (state == S_ERR) error <= 1'b1;
      if (accept) begin
        case (state)
          S_IDLE: begin
            if (rx_data == MAGIC) begin
              error    <= 1'b0;
              byte_cnt <= '0;
              word_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum     <= '0;
`endif
            end
          end
          S_LEN_LO: len_lo  <= rx_data;
          S_LEN_HI: n_words <= rx_count;
          S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0:    asm_word[7:0]   <= rx_data;
              2'd1:    asm_word[15:8]  <= rx_data;
              2'd2:    asm_word[23:16] <= rx_data;
              default: begin
                wr_en    <= 1'b1;
                wr_addr  <= word_cnt[ADDR_WIDTH-1:0];
                wr_data  <= {rx_data, asm_word};
                word_cnt <= word_cnt + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: per-cycle vector table for a nominal load plus hand-written corner sequences.
// Adapts frame contents to IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          core_rst_o;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_rst_o (core_rst_o),
    .done       (done),
    .error      (error)
  );

  typedef struct {
    logic          valid;
    logic [7:0]    data;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_data;
    logic          exp_done;
    logic          exp_ready;
  } vec_t;

  int            total = 0;
  int            bad = 0;
  int            wr_count = 0;
  int            base;
  logic [AW-1:0] log_addr [0:255];
  logic [31:0]   log_data [0:255];
  logic [7:0]    frame_q [$];
  logic [7:0]    tb_csum;
  vec_t          vecs [$];

  // Each write is visible for one cycle; the next rising edge logs it.
  always @(posedge clk) begin
    if (wr_en && wr_count < 256) begin
      log_addr[wr_count] <= wr_addr;
      log_data[wr_count] <= wr_data;
      wr_count <= wr_count + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    rst_i    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " rx_ready"},   32'(rx_ready),   32'd1);
    checkOutput({tag, " wr_en"},      32'(wr_en),      32'd0);
    checkOutput({tag, " wr_addr"},    32'(wr_addr),    32'd0);
    checkOutput({tag, " wr_data"},    wr_data,         32'd0);
    checkOutput({tag, " core_rst_o"}, 32'(core_rst_o), 32'd1);
    checkOutput({tag, " done"},       32'(done),       32'd0);
    checkOutput({tag, " error"},      32'(error),      32'd0);
  endtask

  task automatic pushMagic();
    frame_q.push_back(8'hA5);
    tb_csum = 8'h00;
  endtask

  task automatic pushCount(input logic [15:0] n);
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
  endtask

  task automatic pushWord(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      frame_q.push_back(w[8*k +: 8]);
      tb_csum = tb_csum ^ w[8*k +: 8];
    end
  endtask

  task automatic pushCsum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    frame_q.push_back(tb_csum);
`endif
  endtask

  // Sends the queued bytes with up to max_gap idle cycles before each one.
  task automatic sendQueue(input int max_gap);
    for (int i = 0; i < frame_q.size(); i++) begin
      repeat ($urandom_range(0, max_gap)) applyStimulus(1'b0, 8'($urandom));
      checkOutput($sformatf("ready before byte %0d", i), 32'(rx_ready), 32'd1);
      applyStimulus(1'b1, frame_q[i]);
    end
    frame_q.delete();
  endtask

  task automatic sendNominal();
    pushMagic();
    pushCount(16'd2);
    pushWord(32'h00A00513);
    pushWord(32'h00100593);
    pushCsum();
    sendQueue(0);
  endtask

  initial begin
    rst_i    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idleCycles(2);
    doReset();
    checkResetValues("reset");

    // Nominal frame, cycle by cycle: junk byte, stall gap, then A5 02 00 <w0> <w1> [csum 30].
    vecs.push_back('{1'b1, 8'h00, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'hA5, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'h02, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'h00, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'h13, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1});
    vecs.push_back('{1'b0, 8'h77, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'h05, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'hA0, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'h00, 1'b1, 10'd0, 32'h00A00513, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'h93, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'h05, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'h10, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1});
`ifdef IMEM_LOADER_CHECKSUM_EN
    vecs.push_back('{1'b1, 8'h00, 1'b1, 10'd1, 32'h00100593, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'h30, 1'b0, 10'd0, 32'h0,        1'b1, 1'b0});
`else
    vecs.push_back('{1'b1, 8'h00, 1'b1, 10'd1, 32'h00100593, 1'b1, 1'b0});
`endif
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].data);
      checkOutput($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr) begin
        checkOutput($sformatf("vec%0d wr_addr", i), 32'(wr_addr), 32'(vecs[i].exp_addr));
        checkOutput($sformatf("vec%0d wr_data", i), wr_data, vecs[i].exp_data);
      end
      checkOutput($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].exp_done));
      checkOutput($sformatf("vec%0d core_rst_o", i), 32'(core_rst_o), 32'(!vecs[i].exp_done));
      checkOutput($sformatf("vec%0d rx_ready", i), 32'(rx_ready), 32'(vecs[i].exp_ready));
      checkOutput($sformatf("vec%0d error", i), 32'(error), 32'd0);
    end
    idleCycles(2);
    checkOutput("nominal done sticky", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum, then a correct frame that clears error.
    doReset();
    base = wr_count;
    pushMagic();
    pushCount(16'd2);
    pushWord(32'h00A00513);
    pushWord(32'h00100593);
    frame_q.push_back(~tb_csum);
    sendQueue(0);
    checkOutput("badcs err-state ready", 32'(rx_ready), 32'd0);
    checkOutput("badcs err-state done", 32'(done), 32'd0);
    idleCycles(1);
    checkOutput("badcs error", 32'(error), 32'd1);
    checkOutput("badcs idle ready", 32'(rx_ready), 32'd1);
    checkOutput("badcs core_rst_o", 32'(core_rst_o), 32'd1);
    checkOutput("badcs done", 32'(done), 32'd0);
    pushMagic();
    sendQueue(0);
    checkOutput("badcs magic clears error", 32'(error), 32'd0);
    pushCount(16'd2);
    pushWord(32'h00A00513);
    pushWord(32'h00100593);
    pushCsum();
    sendQueue(1);
    idleCycles(2);
    checkOutput("reload done", 32'(done), 32'd1);
    checkOutput("reload core_rst_o", 32'(core_rst_o), 32'd0);
    checkOutput("reload write count", 32'(wr_count - base), 32'd4);
    checkOutput("reload addr0", 32'(log_addr[base+2]), 32'd0);
    checkOutput("reload data0", log_data[base+2], 32'h00A00513);
    checkOutput("reload addr1", 32'(log_addr[base+3]), 32'd1);
    checkOutput("reload data1", log_data[base+3], 32'h00100593);
`endif

    // Oversize count 1025 is rejected; 1024 is accepted.
    doReset();
    base = wr_count;
    pushMagic();
    pushCount(16'd1025);
    sendQueue(0);
    checkOutput("oversize err-state ready", 32'(rx_ready), 32'd0);
    idleCycles(1);
    checkOutput("oversize error", 32'(error), 32'd1);
    checkOutput("oversize ready", 32'(rx_ready), 32'd1);
    idleCycles(3);
    checkOutput("oversize no writes", 32'(wr_count - base), 32'd0);
    pushMagic();
    pushCount(16'd1024);
    sendQueue(0);
    checkOutput("max count error", 32'(error), 32'd0);
    idleCycles(1);
    checkOutput("max count still ready", 32'(rx_ready), 32'd1);
    checkOutput("max count no error", 32'(error), 32'd0);

    // Junk bytes and random valid gaps inside a 3-word frame.
    doReset();
    base = wr_count;
    frame_q.push_back(8'h00);
    frame_q.push_back(8'hFF);
    pushMagic();
    pushCount(16'd3);
    pushWord(32'h11223344);
    pushWord(32'hDEADBEEF);
    pushWord(32'h00000001);
    pushCsum();
    sendQueue(3);
    idleCycles(2);
    checkOutput("gaps write count", 32'(wr_count - base), 32'd3);
    checkOutput("gaps addr0", 32'(log_addr[base]),   32'd0);
    checkOutput("gaps data0", log_data[base],        32'h11223344);
    checkOutput("gaps addr1", 32'(log_addr[base+1]), 32'd1);
    checkOutput("gaps data1", log_data[base+1],      32'hDEADBEEF);
    checkOutput("gaps addr2", 32'(log_addr[base+2]), 32'd2);
    checkOutput("gaps data2", log_data[base+2],      32'h00000001);
    checkOutput("gaps done", 32'(done), 32'd1);
    checkOutput("gaps error", 32'(error), 32'd0);

    // Reset after the 6th payload byte, then a full restart from address 0.
    doReset();
    base = wr_count;
    pushMagic();
    pushCount(16'd2);
    pushWord(32'h00A00513);
    frame_q.push_back(8'h93);
    frame_q.push_back(8'h05);
    sendQueue(0);
    doReset();
    checkResetValues("midreset");
    sendNominal();
    idleCycles(2);
    checkOutput("restart write count", 32'(wr_count - base), 32'd3);
    checkOutput("restart addr0", 32'(log_addr[base+1]), 32'd0);
    checkOutput("restart data0", log_data[base+1],      32'h00A00513);
    checkOutput("restart addr1", 32'(log_addr[base+2]), 32'd1);
    checkOutput("restart data1", log_data[base+2],      32'h00100593);
    checkOutput("restart done", 32'(done), 32'd1);

    // Empty image.
    doReset();
    base = wr_count;
    pushMagic();
    pushCount(16'd0);
    pushCsum();
    sendQueue(0);
    checkOutput("empty done", 32'(done), 32'd1);
    checkOutput("empty core_rst_o", 32'(core_rst_o), 32'd0);
    checkOutput("empty ready", 32'(rx_ready), 32'd0);
    idleCycles(2);
    checkOutput("empty no writes", 32'(wr_count - base), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the core's instruction memory. It accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them to consecutive word addresses of `instr_mem` through a dedicated write port. It holds the core in reset until a complete, valid image has been written, then releases it.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 10: word-address width of the instruction memory; capacity is 2^ADDR_WIDTH words.

**Ports**
- `clk`, input, 1: single clock.
- `rst_i`, input, 1: reset.
- `rx_valid`, input, 1: byte-stream data valid.
- `rx_data`, input, 8: stream byte.
- `rx_ready`, output, 1: loader accepts `rx_data`.
- `wr_en`, output, 1: instruction-memory write strobe, one cycle per word.
- `wr_addr`, output, ADDR_WIDTH: word address of the write.
- `wr_data`, output, 32: word to write.
- `core_rst_o`, output, 1: hold core/pc in reset while high.
- `done`, output, 1: image loaded successfully; sticky.
- `error`, output, 1: last frame was rejected; sticky until the next magic byte.

**Already decided**
- One clock, `clk`.
- Reset `rst_i` is synchronous and active-high.

## Operation

- **Frame format:** magic `0xA5`, then count low byte, then count high byte (16-bit word count N), then 4·N payload bytes (each word LSB first), then 1 checksum byte.
- **States:**
  - IDLE: non-0xA5 bytes are discarded; 0xA5 clears `error` and moves to LEN_LO.
  - LEN_LO: always moves to LEN_HI.
  - LEN_HI:
    - N = 0 goes to CSUM.
    - N > 2^ADDR_WIDTH goes to ERR.
    - Otherwise goes to DATA.
  - DATA:
    - Byte counter 0..3 shifts bytes into a 32-bit assembly register: byte k goes to bits [8k+7:8k].
    - The 4th byte triggers a write.
    - After word N, goes to CSUM.
  - CSUM: compares the received byte to the running XOR of all payload bytes. Match goes to DONE; mismatch goes to ERR.
  - DONE: terminal. `rx_ready`=0. Only `rst_i` leaves it.
  - ERR: one cycle. Sets `error`, then returns to IDLE. Any partially written image is not cleared.
- **Write address:**
  - Starts at 0 and increments after each write.
  - Reaches at most N−1, so it never wraps.
- **Handshake:**
  - A byte transfers on a cycle with `rx_valid`=1 and `rx_ready`=1.
  - `rx_ready`=1 in IDLE, LEN_LO, LEN_HI, DATA and CSUM; 0 in ERR and DONE.
  - A `rx_valid` gap of any length stalls the FSM with no state change.
- **`core_rst_o`:** 1 in every state except DONE.

## Timing

- **Reset values:**
  - State IDLE.
  - `rx_ready`=1, `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `core_rst_o`=1, `done`=0, `error`=0.
  - Byte counter, word counter and checksum cleared.
- **Write latency:** `wr_en`, `wr_addr` and `wr_data` are registered. They are valid for exactly the one cycle after the 4th byte of a word is accepted.
- **Throughput:** the loader accepts one byte per cycle back-to-back, so a word is written every 4 cycles at full rate.
- **Release:** `done` rises and `core_rst_o` falls on the same edge, one cycle after the checksum byte is accepted. The core fetches address 0 on the following cycle.
- **Last word:** when the final-word write and the transition to CSUM coincide, the write still issues.
- **Reset mid-frame:** `rst_i` during any state returns to reset values on the next edge. Writes already issued stand.

## Configuration

- **`IMEM_LOADER_CHECKSUM_EN` defined:** CSUM state, running XOR and mismatch error are implemented as above.
- **Not defined:**
  - No checksum byte is present in the frame.
  - After the last payload word (or N = 0), the FSM goes directly to DONE.
  - `error` is raised only by an oversize count.

## Test plan

- **Nominal load, checksum enabled:** send A5 02 00 13 05 A0 00 93 05 10 00 plus the correct XOR byte.
  - Expect a write of 0x00A00513 at address 0, then 0x00100593 at address 1.
  - Then `done`=1 and `core_rst_o`=0.
- **Bad checksum:** same frame with the final byte inverted.
  - Expect `error`=1, `done`=0, `core_rst_o`=1, FSM back in IDLE.
  - A following correct frame loads normally and clears `error`.
- **Oversize count:** with ADDR_WIDTH=10, send A5 01 04 (N=1025).
  - Expect `error`=1 and no `wr_en` pulses.
- **Stalls and junk:** send junk 00 FF before A5, then random `rx_valid` gaps inside a 3-word frame.
  - Expect 3 writes with correct data and addresses 0..2, independent of the gaps.
- **Reset mid-frame:** pulse `rst_i` after the 6th payload byte.
  - All outputs return to reset values.
  - A restarted full frame loads from address 0.
- **Empty image:** send A5 00 00 plus checksum 00 (macro on), or A5 00 00 (macro off).
  - Expect `done`=1 with zero writes.
